// File: rtl/single_period_cpu.sv
// Single-cycle MIPS-subset CPU: fetch, decode, execute, memory access and
// write-back all complete within one clk period.

module instr_mem #(
  parameter int INSTR_LEN = 32
) (
  input  logic [7:0]           word_addr,
  output logic [INSTR_LEN-1:0] instr
);
  // Program storage is loaded from outside (bench or preload); no write port.
  logic [INSTR_LEN-1:0] imem [256] = '{default: '0};

  assign instr = imem[word_addr];
endmodule

module single_period_cpu #(
  parameter int ADDR_LEN  = 32,
  parameter int INSTR_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADDR_LEN-1:0]  pc_out,
  output logic [INSTR_LEN-1:0] instr_out
);
  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  logic [ADDR_LEN-1:0]  pc;
  logic [ADDR_LEN-1:0]  pc_plus4;
  logic [ADDR_LEN-1:0]  pc_next;
  logic [INSTR_LEN-1:0] instr;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] target;

  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] dmem [256] = '{default: '0};

  logic signed [DATA_W-1:0] rs_val;
  logic signed [DATA_W-1:0] rt_val;
  logic signed [DATA_W-1:0] imm_sext;
  logic        [DATA_W-1:0] imm_zext;
  logic        [7:0]        mem_idx;

  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_reg;
  logic              wb_en;
  logic              mem_we;
  logic              take_branch;
  logic              take_jump;

  instr_mem #(
    .INSTR_LEN (INSTR_LEN)
  ) imem (
    .word_addr (pc[9:2]),
    .instr     (instr)
  );

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];

  // $0 is hardwired to zero on read; the write port also refuses it.
  assign rs_val   = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_val   = (rt == 5'd0) ? '0 : regs[rt];
  assign imm_sext = sext16(imm);
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm};
  assign mem_idx  = 8'((rs_val + imm_sext) >> 2);

  always_comb begin
    wb_en       = 1'b0;
    wb_reg      = rd;
    wb_data     = '0;
    mem_we      = 1'b0;
    take_branch = 1'b0;
    take_jump   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wb_en = 1'b1;
        case (funct)
          FN_ADD:  wb_data = rs_val + rt_val;
          FN_SUB:  wb_data = rs_val - rt_val;
          FN_AND:  wb_data = rs_val & rt_val;
          FN_OR:   wb_data = rs_val | rt_val;
          FN_XOR:  wb_data = rs_val ^ rt_val;
          FN_SLT:  wb_data = DATA_W'(rs_val < rt_val);
          FN_SLTU: wb_data = DATA_W'($unsigned(rs_val) < $unsigned(rt_val));
          FN_SLL:  wb_data = rt_val << shamt;
          FN_SRL:  wb_data = $unsigned(rt_val) >> shamt;
          FN_SRA:  wb_data = rt_val >>> shamt;
          default: wb_en = 1'b0;
        endcase
      end
      OP_ADDI: begin
        wb_en   = 1'b1;
        wb_reg  = rt;
        wb_data = rs_val + imm_sext;
      end
      OP_ANDI: begin
        wb_en   = 1'b1;
        wb_reg  = rt;
        wb_data = $unsigned(rs_val) & imm_zext;
      end
      OP_ORI: begin
        wb_en   = 1'b1;
        wb_reg  = rt;
        wb_data = $unsigned(rs_val) | imm_zext;
      end
      OP_LW: begin
        wb_en   = 1'b1;
        wb_reg  = rt;
        wb_data = dmem[mem_idx];
      end
      OP_SW:   mem_we      = 1'b1;
      OP_BEQ:  take_branch = (rs_val == rt_val);
      OP_J:    take_jump   = 1'b1;
      default: ;
    endcase
  end

  assign pc_plus4 = pc + ADDR_LEN'(4);

  always_comb begin
    pc_next = pc_plus4;
    if (take_jump)
      pc_next = {pc_plus4[ADDR_LEN-1:28], target, 2'b00};
    else if (take_branch)
      pc_next = pc_plus4 + ADDR_LEN'({imm_sext[DATA_W-3:0], 2'b00});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pc <= '0;
    else
      pc <= pc_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wb_en && (wb_reg != 5'd0)) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // Data memory keeps its contents across reset, but a store is suppressed
  // while reset is held so an aborted sw leaves no trace.
  always_ff @(posedge clk or negedge rst) begin
    if (rst && mem_we)
      dmem[mem_idx] <= rt_val;
  end

  assign pc_out    = pc;
  assign instr_out = instr;
endmodule

// File: tb/tb_single_period_cpu.sv
// Directed and randomized program bench for single_period_cpu, checked
// against an instruction-level reference model.

module tb_single_period_cpu;
  logic        clk;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] m_reg  [32];
  logic [31:0] m_pc;

  single_period_cpu #(
    .ADDR_LEN  (32),
    .INSTR_LEN (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_out    (pc_out),
    .instr_out (instr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] enc_r(int fn, int rd, int rs, int rt, int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rt, int rs, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int tgt);
    return {6'd2, 26'(tgt)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.imem.imem[idx] = w;
    m_imem[idx] = w;
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
  endtask

  // One architectural instruction, computed straight from the ISA rules.
  task automatic model_step();
    logic [31:0] ins, a, b, se, ea, res, nxt;
    logic [5:0]  op, fn;
    int          dst, sh;
    bit          wr;
    ins = m_imem[(m_pc / 4) % 256];
    op  = ins[31:26];
    fn  = ins[5:0];
    a   = m_reg[ins[25:21]];
    b   = m_reg[ins[20:16]];
    sh  = int'(ins[10:6]);
    se  = {{16{ins[15]}}, ins[15:0]};
    ea  = a + se;
    nxt = m_pc + 32'd4;
    wr  = 0;
    dst = 0;
    res = 32'd0;
    if (op == 6'h00) begin
      dst = int'(ins[15:11]);
      wr  = 1;
      case (fn)
        6'h20:   res = a + b;
        6'h22:   res = a - b;
        6'h24:   res = a & b;
        6'h25:   res = a | b;
        6'h26:   res = a ^ b;
        6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2B:   res = (a < b) ? 32'd1 : 32'd0;
        6'h00:   res = b << sh;
        6'h02:   res = b >> sh;
        6'h03:   res = $signed(b) >>> sh;
        default: wr = 0;
      endcase
    end else begin
      dst = int'(ins[20:16]);
      case (op)
        6'h08: begin wr = 1; res = a + se; end
        6'h0C: begin wr = 1; res = a & {16'h0, ins[15:0]}; end
        6'h0D: begin wr = 1; res = a | {16'h0, ins[15:0]}; end
        6'h23: begin wr = 1; res = m_dmem[(ea / 4) % 256]; end
        6'h2B: m_dmem[(ea / 4) % 256] = b;
        6'h04: if (a == b) nxt = nxt + se * 4;
        6'h02: nxt = (nxt & 32'hF000_0000) | (ins[25:0] * 4);
        default: ;
      endcase
    end
    if (wr && dst != 0) m_reg[dst] = res;
    m_pc = nxt;
  endtask

  task automatic run_steps(input int n);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      check("pc", pc_out, m_pc);
      check("instr", instr_out, m_imem[(m_pc / 4) % 256]);
      for (int r = 0; r < 32; r++)
        check($sformatf("reg%0d", r), dut.regs[r], m_reg[r]);
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] fl [10];
    logic [5:0] undef_op [5];
    fl       = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
    undef_op = '{6'h01, 6'h03, 6'h05, 6'h10, 6'h3F};
    rst = 1'b0;
    for (int i = 0; i < 256; i++) m_dmem[i] = 32'd0;
    model_reset();
    #1;

    for (int i = 0; i < 256; i++) put(i, 32'd0);
    put( 0, enc_i(8'h08,  9,  0, 10));
    put( 1, enc_i(8'h08, 10,  0, 5));
    put( 2, enc_r(8'h20, 11,  9, 10, 0));
    put( 3, enc_r(8'h22, 12,  9, 10, 0));
    put( 4, enc_r(8'h24, 13,  9, 10, 0));
    put( 5, enc_r(8'h25, 14,  9, 10, 0));
    put( 6, enc_r(8'h26, 15,  9, 10, 0));
    put( 7, enc_r(8'h00, 16,  0, 10, 2));
    put( 8, enc_r(8'h02, 17,  0,  9, 1));
    put( 9, enc_i(8'h08, 18,  0, -5));
    put(10, enc_r(8'h03, 19,  0, 18, 1));
    put(11, enc_r(8'h2A, 20, 10,  9, 0));
    put(12, enc_r(8'h2B, 21, 10,  9, 0));
    put(13, enc_r(8'h2A, 22,  9, 10, 0));
    put(14, enc_r(8'h2B, 23, 18, 10, 0));
    put(15, enc_i(8'h2B,  9,  0, 0));
    put(16, enc_i(8'h23, 15,  0, 0));
    put(17, enc_i(8'h0C, 25, 18, 16'hFFFF));
    put(18, enc_i(8'h08,  8,  0, 1));
    put(19, enc_i(8'h04,  0,  8, 8));
    put(20, enc_i(8'h04,  8,  8, 4));
    put(21, enc_i(8'h08, 26,  0, 99));
    put(22, enc_i(8'h2B,  8,  0, 4));
    put(23, enc_i(8'h08, 27,  0, 1));
    put(24, enc_i(8'h08, 28,  0, 2));
    put(25, enc_i(8'h08,  0,  0, 7));
    put(26, enc_i(8'h08, 29,  0, 16'h123));
    put(27, enc_j(0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc_out, 32'd0);
    for (int r = 0; r < 32; r++)
      check($sformatf("reset_reg%0d", r), dut.regs[r], 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    run_steps(7);
    check("xor_r15", dut.regs[15], 32'd15);
    run_steps(13);
    check("beq_not_taken_pc", pc_out, 32'h50);
    run_steps(1);
    check("beq_taken_pc", pc_out, 32'h64);
    run_steps(3);
    check("j_zero_pc", pc_out, 32'd0);
    check("add_r11",  dut.regs[11], 32'd15);
    check("sub_r12",  dut.regs[12], 32'd5);
    check("and_r13",  dut.regs[13], 32'd0);
    check("or_r14",   dut.regs[14], 32'd15);
    check("sll_r16",  dut.regs[16], 32'd20);
    check("srl_r17",  dut.regs[17], 32'd5);
    check("addi_neg_r18", dut.regs[18], 32'hFFFF_FFFB);
    check("sra_r19",  dut.regs[19], 32'hFFFF_FFFD);
    check("slt_r20",  dut.regs[20], 32'd1);
    check("sltu_r21", dut.regs[21], 32'd1);
    check("slt_r22",  dut.regs[22], 32'd0);
    check("sltu_neg_r23", dut.regs[23], 32'd0);
    check("lw_r15",   dut.regs[15], 32'd10);
    check("andi_r25", dut.regs[25], 32'h0000_FFFB);
    check("skip_r26", dut.regs[26], 32'd0);
    check("skip_dmem1", dut.dmem[1], 32'd0);
    check("r0_zero",  dut.regs[0], 32'd0);
    check("r0_src_r29", dut.regs[29], 32'h123);

    run_steps(5);
    #1 rst = 1'b0;
    #1;
    check("async_reset_pc", pc_out, 32'd0);
    for (int r = 0; r < 32; r++)
      check($sformatf("midreset_reg%0d", r), dut.regs[r], 32'd0);
    model_reset();
    put(0, enc_i(8'h2B, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("dmem_kept_in_reset", dut.dmem[0], 32'd10);

    for (int i = 0; i < 256; i++) put(i, 32'd0);
    for (int i = 0; i < 8; i++)
      put(i, enc_i(8'h08, i + 1, 0, int'($urandom_range(0, 65535))));
    for (int i = 8; i < 96; i++) begin
      int sel, rd, rs, rt;
      sel = int'($urandom_range(0, 9));
      rd  = int'($urandom_range(0, 31));
      rs  = int'($urandom_range(0, 12));
      rt  = int'($urandom_range(0, 12));
      case (sel)
        0, 1, 2: put(i, enc_r(int'(fl[$urandom_range(0, 9)]), rd, rs, rt,
                              int'($urandom_range(0, 31))));
        3: put(i, enc_i(($urandom_range(0, 2) == 0) ? 8'h08 :
                        ($urandom_range(0, 1) == 0) ? 8'h0C : 8'h0D,
                        rd, rs, int'($urandom_range(0, 65535))));
        4: put(i, enc_i(8'h23, rd, rs, int'($urandom_range(0, 64))));
        5: put(i, enc_i(8'h2B, rt, rs, int'($urandom_range(0, 64))));
        6: put(i, enc_i(8'h04, rt, rs, int'($urandom_range(0, 10)) - 4));
        7: put(i, enc_j(int'($urandom_range(8, 95))));
        8: put(i, {undef_op[$urandom_range(0, 4)], 26'($urandom)});
        default: put(i, enc_r(int'($urandom_range(0, 63)), rd, rs, rt,
                              int'($urandom_range(0, 31))));
      endcase
    end
    @(posedge clk);
    #2 rst = 1'b1;
    run_steps(400);
    for (int i = 0; i < 256; i++)
      check($sformatf("dmem%0d", i), dut.dmem[i], m_dmem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
